// File: rtl/accel_sample_filter_if.sv
// Sample-in / average-out handshake bundle for accel_sample_filter.
// master = producer of samples and consumer of averages; slave = the filter.
interface accel_sample_filter_if;
  logic        in_valid;
  logic [15:0] accel_x;
  logic [15:0] accel_y;
  logic [15:0] accel_z;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] avg_x;
  logic [15:0] avg_y;
  logic [15:0] avg_z;

  modport master (
    output in_valid, accel_x, accel_y, accel_z, out_ready,
    input  out_valid, avg_x, avg_y, avg_z
  );

  modport slave (
    input  in_valid, accel_x, accel_y, accel_z, out_ready,
    output out_valid, avg_x, avg_y, avg_z
  );
endinterface

// File: rtl/accel_sample_filter.sv
// Per-axis boxcar moving average over 2**LOG2_DEPTH accelerometer samples, valid/ready output.
// Optional motion detector enabled by defining ACCEL_MOTION_EN.
module accel_sample_filter_lane #(
  parameter int          LOG2_DEPTH    = 2,
  parameter logic [15:0] MOTION_THRESH = 16'd256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  run,
  input  logic [LOG2_DEPTH-1:0] wp,
  input  logic [15:0]           sample,
`ifdef ACCEL_MOTION_EN
  output logic                  trip,
`endif
  output logic [15:0]           mean
);
  localparam int N  = 1 << LOG2_DEPTH;
  localparam int SW = 16 + LOG2_DEPTH;

  logic [15:0]          mem [N];
  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] new_ext;
  logic signed [SW-1:0] old_ext;

  assign new_ext = {{LOG2_DEPTH{sample[15]}}, sample};
  // While filling, the slot being overwritten holds stale data, so nothing is retired.
  assign old_ext = run ? {{LOG2_DEPTH{mem[wp][15]}}, mem[wp]} : '0;
  assign mean    = 16'(sum >>> LOG2_DEPTH);

  always_ff @(posedge clk) begin
    if (reset)         sum <= '0;
    else if (in_valid) sum <= sum - old_ext + new_ext;
  end

  always_ff @(posedge clk) begin
    if (in_valid && !reset) mem[wp] <= sample;
  end

`ifdef ACCEL_MOTION_EN
  logic [16:0] diff;
  logic [16:0] mag;

  // mean here is still the pre-sample average: sum updates on this same edge.
  assign diff = {sample[15], sample} - {mean[15], mean};
  assign mag  = diff[16] ? (~diff + 17'd1) : diff;

  always_ff @(posedge clk) begin
    if (reset)                trip <= 1'b0;
    else if (in_valid && run) trip <= (mag > {1'b0, MOTION_THRESH});
  end
`endif
endmodule

module accel_sample_filter #(
  parameter int          LOG2_DEPTH    = 2,
  parameter logic [15:0] MOTION_THRESH = 16'd256
) (
  input  logic                 clk,
  input  logic                 reset,
  accel_sample_filter_if.slave bus,
  output logic                 warm,
  output logic                 overrun,
  input  logic                 clr_overrun,
  output logic                 motion
);
  localparam int NUM_LANES = 3;
  localparam int VEC_W     = 16;
  localparam int STAGES    = 1;
  localparam logic [LOG2_DEPTH-1:0] WP_ONE  = 1;
  localparam logic [LOG2_DEPTH-1:0] WP_LAST = '1;

  typedef enum logic {FILL, RUN} state_t;
  state_t state_q, state_d;

  logic [LOG2_DEPTH-1:0]             wp;
  logic [STAGES:1]                   vld_pipe;
  logic [NUM_LANES-1:0][VEC_W-1:0]   samp;
  logic [NUM_LANES-1:0][VEC_W-1:0]   mean;
  logic [NUM_LANES-1:0][VEC_W-1:0]   avg_q;
  logic                              out_valid_q;
  logic                              run;
  logic                              load;

  assign samp = {bus.accel_z, bus.accel_y, bus.accel_x};
  assign run  = (state_q == RUN);
  assign warm = run;
  // Stage-2 load; warm is already set by the time the Nth sample reaches here.
  assign load = vld_pipe[STAGES] & warm;

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (bus.in_valid && wp == WP_LAST) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      wp      <= '0;
    end else begin
      state_q <= state_d;
      if (bus.in_valid) wp <= wp + WP_ONE;
    end
  end

`ifdef ACCEL_MOTION_EN
  logic [NUM_LANES-1:0] trip;
`endif

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    accel_sample_filter_lane #(
      .LOG2_DEPTH   (LOG2_DEPTH),
      .MOTION_THRESH(MOTION_THRESH)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .in_valid(bus.in_valid),
      .run     (run),
      .wp      (wp),
      .sample  (samp[g]),
`ifdef ACCEL_MOTION_EN
      .trip    (trip[g]),
`endif
      .mean    (mean[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe    <= '0;
      avg_q       <= '0;
      out_valid_q <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      vld_pipe[1] <= bus.in_valid;
      if (load) begin
        avg_q       <= mean;
        out_valid_q <= 1'b1;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      // Overwrite of a pending average sets; set beats a same-cycle clear.
      if (load && out_valid_q && !bus.out_ready) overrun <= 1'b1;
      else if (clr_overrun)                     overrun <= 1'b0;
    end
  end

`ifdef ACCEL_MOTION_EN
  always_ff @(posedge clk) begin
    if (reset)                 motion <= 1'b0;
    else if (vld_pipe[STAGES]) motion <= |trip;
  end
`else
  assign motion = 1'b0;
`endif

  assign bus.out_valid = out_valid_q;
  assign bus.avg_x     = avg_q[0];
  assign bus.avg_y     = avg_q[1];
  assign bus.avg_z     = avg_q[2];
endmodule

// File: tb/tb_accel_sample_filter.sv
// Directed self-checking bench for accel_sample_filter, LOG2_DEPTH=2 (N=4), MOTION_THRESH=0x0100.
module tb_accel_sample_filter;
  logic clk = 1'b0;
  logic reset;
  logic warm, overrun, clr_overrun, motion;
  int   n_checks = 0;
  int   n_fail   = 0;

  accel_sample_filter_if bus ();

  accel_sample_filter #(.LOG2_DEPTH(2), .MOTION_THRESH(16'h0100)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .warm       (warm),
    .overrun    (overrun),
    .clr_overrun(clr_overrun),
    .motion     (motion)
  );

  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // One-cycle strobe; returns 1ns after the capturing edge (T+1).
  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    bus.in_valid = 1'b1;
    bus.accel_x = x; bus.accel_y = y; bus.accel_z = z;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    n_checks++; if (warm !== 1'b0) begin n_fail++; $display("FAIL reset_warm got=%b exp=0", warm); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    n_checks++; if (motion !== 1'b0) begin n_fail++; $display("FAIL reset_motion got=%b exp=0", motion); end
    n_checks++; if ({bus.avg_x, bus.avg_y, bus.avg_z} !== 48'h0) begin n_fail++; $display("FAIL reset_avg got=%h exp=0", {bus.avg_x, bus.avg_y, bus.avg_z}); end
  endtask

  task automatic test_warmup();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send(16'h0010, 16'h0020, 16'hFFF0);
      n_checks++; if (warm !== 1'b0) begin n_fail++; $display("FAIL warmup_early_warm i=%0d got=%b exp=0", i, warm); end
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL warmup_early_valid i=%0d got=%b exp=0", i, bus.out_valid); end
    end
    send(16'h0010, 16'h0020, 16'hFFF0);
    n_checks++; if (warm !== 1'b1) begin n_fail++; $display("FAIL warmup_warm got=%b exp=1", warm); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL warmup_valid_t1 got=%b exp=0", bus.out_valid); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL warmup_valid_t2 got=%b exp=1", bus.out_valid); end
    n_checks++; if (bus.avg_x !== 16'h0010) begin n_fail++; $display("FAIL warmup_avg_x got=%h exp=0010", bus.avg_x); end
    n_checks++; if (bus.avg_y !== 16'h0020) begin n_fail++; $display("FAIL warmup_avg_y got=%h exp=0020", bus.avg_y); end
    n_checks++; if (bus.avg_z !== 16'hFFF0) begin n_fail++; $display("FAIL warmup_avg_z got=%h exp=fff0", bus.avg_z); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL warmup_accept got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_neg_rounding();
    for (int i = 0; i < 3; i++) send(16'hFFFF, 16'h0020, 16'hFFF0);
    send(16'hFFFE, 16'h0020, 16'hFFF0);
    tick();
    n_checks++; if (bus.avg_x !== 16'hFFFE) begin n_fail++; $display("FAIL neg_floor got=%h exp=fffe", bus.avg_x); end
    n_checks++; if (bus.avg_z !== 16'hFFF0) begin n_fail++; $display("FAIL neg_avg_z got=%h exp=fff0", bus.avg_z); end
    send(16'h0004, 16'h0020, 16'hFFF0);
    tick();
    n_checks++; if (bus.avg_x !== 16'h0000) begin n_fail++; $display("FAIL neg_slide1 got=%h exp=0000", bus.avg_x); end
    for (int i = 0; i < 3; i++) send(16'h0004, 16'h0020, 16'hFFF0);
    tick();
    n_checks++; if (bus.avg_x !== 16'h0004) begin n_fail++; $display("FAIL neg_slide4 got=%h exp=0004", bus.avg_x); end
  endtask

  task automatic test_extremes();
    for (int i = 0; i < 4; i++) send(16'h7FFF, 16'h0020, 16'hFFF0);
    tick();
    n_checks++; if (bus.avg_x !== 16'h7FFF) begin n_fail++; $display("FAIL ext_max got=%h exp=7fff", bus.avg_x); end
    send(16'h8000, 16'h0020, 16'hFFF0);
    tick();
    n_checks++; if (bus.avg_x !== 16'h3FFF) begin n_fail++; $display("FAIL ext_mixed got=%h exp=3fff", bus.avg_x); end
    for (int i = 0; i < 3; i++) send(16'h8000, 16'h0020, 16'hFFF0);
    tick();
    n_checks++; if (bus.avg_x !== 16'h8000) begin n_fail++; $display("FAIL ext_min got=%h exp=8000", bus.avg_x); end
  endtask

  task automatic test_backpressure();
    tick();
    bus.out_ready = 1'b0;
    send(16'h0100, 16'h0020, 16'hFFF0);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_idle got=%b exp=0", bus.out_valid); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid1 got=%b exp=1", bus.out_valid); end
    n_checks++; if (bus.avg_x !== 16'hA040) begin n_fail++; $display("FAIL bp_avg1 got=%h exp=a040", bus.avg_x); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL bp_no_overrun got=%b exp=0", overrun); end
    tick();
    send(16'h0100, 16'h0020, 16'hFFF0);
    n_checks++; if ({bus.out_valid, bus.avg_x} !== {1'b1, 16'hA040}) begin n_fail++; $display("FAIL bp_hold got=%b/%h exp=1/a040", bus.out_valid, bus.avg_x); end
    tick();
    n_checks++; if (bus.avg_x !== 16'hC080) begin n_fail++; $display("FAIL bp_avg2 got=%h exp=c080", bus.avg_x); end
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL bp_overrun got=%b exp=1", overrun); end
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid2 got=%b exp=1", bus.out_valid); end
    clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL bp_clear got=%b exp=0", overrun); end
    send(16'h0100, 16'h0020, 16'hFFF0);
    clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL bp_set_wins got=%b exp=1", overrun); end
    n_checks++; if (bus.avg_x !== 16'hE0C0) begin n_fail++; $display("FAIL bp_avg3 got=%h exp=e0c0", bus.avg_x); end
    clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL bp_clear2 got=%b exp=0", overrun); end
    bus.out_ready = 1'b1;
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_accept got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) send(16'h0000, 16'h0000, 16'h0000);
    tick(); tick(); tick();
    bus.in_valid = 1'b1;
    bus.accel_x = 16'd4;  tick();
    bus.accel_x = 16'd8;  tick();
    n_checks++; if ({bus.out_valid, bus.avg_x} !== {1'b1, 16'd1}) begin n_fail++; $display("FAIL b2b_1 got=%b/%h exp=1/0001", bus.out_valid, bus.avg_x); end
    bus.accel_x = 16'd12; tick();
    n_checks++; if ({bus.out_valid, bus.avg_x} !== {1'b1, 16'd3}) begin n_fail++; $display("FAIL b2b_2 got=%b/%h exp=1/0003", bus.out_valid, bus.avg_x); end
    bus.accel_x = 16'd16; tick();
    n_checks++; if ({bus.out_valid, bus.avg_x} !== {1'b1, 16'd6}) begin n_fail++; $display("FAIL b2b_3 got=%b/%h exp=1/0006", bus.out_valid, bus.avg_x); end
    bus.in_valid = 1'b0;  tick();
    n_checks++; if ({bus.out_valid, bus.avg_x} !== {1'b1, 16'd10}) begin n_fail++; $display("FAIL b2b_4 got=%b/%h exp=1/000a", bus.out_valid, bus.avg_x); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drop got=%b exp=0", bus.out_valid); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun got=%b exp=0", overrun); end
  endtask

  task automatic test_reset_mid_window();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(16'h0100, 16'h0100, 16'h0100);
    reset = 1'b1;
    bus.in_valid = 1'b1; bus.accel_x = 16'h7000;
    tick();
    reset = 1'b0; bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    n_checks++; if ({bus.out_valid, overrun, warm} !== 3'b000) begin n_fail++; $display("FAIL rmw_flags got=%b exp=000", {bus.out_valid, overrun, warm}); end
    n_checks++; if (bus.avg_x !== 16'h0000) begin n_fail++; $display("FAIL rmw_avg_clr got=%h exp=0000", bus.avg_x); end
    for (int i = 0; i < 3; i++) send(16'h0040, 16'h0040, 16'h0040);
    tick(); tick();
    n_checks++; if ({bus.out_valid, warm} !== 2'b00) begin n_fail++; $display("FAIL rmw_fill got=%b exp=00", {bus.out_valid, warm}); end
    send(16'h0040, 16'h0040, 16'h0040);
    n_checks++; if (warm !== 1'b1) begin n_fail++; $display("FAIL rmw_warm got=%b exp=1", warm); end
    tick();
    n_checks++; if ({bus.out_valid, bus.avg_x, bus.avg_y} !== {1'b1, 16'h0040, 16'h0040}) begin n_fail++; $display("FAIL rmw_avg got=%b/%h/%h exp=1/0040/0040", bus.out_valid, bus.avg_x, bus.avg_y); end
  endtask

  task automatic test_motion();
    logic exp_trip;
`ifdef ACCEL_MOTION_EN
    exp_trip = 1'b1;
`else
    exp_trip = 1'b0;
`endif
    do_reset();
    for (int i = 0; i < 4; i++) send(16'h0000, 16'h0000, 16'h0000);
    tick(); tick(); tick();
    n_checks++; if (motion !== 1'b0) begin n_fail++; $display("FAIL motion_quiet got=%b exp=0", motion); end
    send(16'h0200, 16'h0000, 16'h0000);
    n_checks++; if (motion !== 1'b0) begin n_fail++; $display("FAIL motion_t1 got=%b exp=0", motion); end
    tick();
    n_checks++; if (motion !== exp_trip) begin n_fail++; $display("FAIL motion_trip got=%b exp=%b", motion, exp_trip); end
    send(16'h0080, 16'h0000, 16'h0000);
    tick();
    n_checks++; if (motion !== 1'b0) begin n_fail++; $display("FAIL motion_settle got=%b exp=0", motion); end
  endtask

  initial begin
    reset = 1'b1;
    clr_overrun = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.accel_x = '0; bus.accel_y = '0; bus.accel_z = '0;
    test_reset();
    test_warmup();
    test_neg_rounding();
    test_extremes();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_window();
    test_motion();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
